du_dump_collector: RTL and testbench

- Host-side counterpart of the debug unit's dump stream, used for on-board self-test and simulation.
- Sends one command byte to the debug unit through a UART, then receives the dump frame the debug unit transmits:
  - PC
  - register bank
  - data memory
- Reassembles the received bytes into 32-bit words and writes them sequentially into a capture RAM.
- Flags completion or an inter-byte timeout.

---
 rtl/du_dump_collector.sv | 173 +++++++++++++++++
 tb/tb_du_dump_collector.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_dump_collector.sv
// Host-side dump collector: sends one command byte over the UART, then reassembles
// the debug unit's PC / register bank / data memory dump into a capture RAM.
module du_dump_collector #(
  parameter int BYTE       = 8,
  parameter int DWORD      = 32,
  parameter int RB_ADDR    = 5,
  parameter int ADDR       = 5,
  parameter int NB_WADDR   = 7,
  parameter int NB_TIMEOUT = 20,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT = 20'd1000000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [BYTE-1:0]     i_cmd,
  output logic [BYTE-1:0]     o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  input  logic [BYTE-1:0]     i_rx_data,
  input  logic                i_rx_done,
  output logic                o_wr_en,
  output logic [NB_WADDR-1:0] o_wr_addr,
  output logic [DWORD-1:0]    o_wr_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [NB_WADDR-1:0] o_word_count
);

  localparam int FRAME_WORDS = 1 + (1 << RB_ADDR) + (1 << ADDR);
  localparam logic [NB_WADDR-1:0] FRAME_W = NB_WADDR'(FRAME_WORDS);

  // state   | meaning
  // IDLE    | waiting for i_start; done/error flags held
  // SEND    | command byte presented, transmit requested
  // WAIT_TX | waiting for the transmitter, timeout running
  // RECV    | assembling bytes into words, timeout between bytes
  // DONE    | full frame captured
  // ERROR   | inter-byte timeout expired
  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [BYTE-1:0]       cmd_q, cmd_d;
  logic [DWORD-1:0]      word_q, word_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [NB_WADDR-1:0]   word_cnt_q, word_cnt_d;
  logic [NB_WADDR-1:0]   wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [NB_TIMEOUT-1:0] tmo_inc;
  logic                  tmo_hit;
  logic [NB_WADDR-1:0]   word_cnt_inc;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_en_q    <= wr_en_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Saturating count; expiry is the cycle in which the count would land on TIMEOUT.
  always_comb begin
    tmo_inc      = (tmo_q == TIMEOUT) ? tmo_q : tmo_q + 1'b1;
    tmo_hit      = (tmo_inc == TIMEOUT);
    word_cnt_inc = word_cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_en_d    = 1'b0;
    tmo_d      = tmo_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cmd_d      = i_cmd;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_d     = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          wr_addr_d  = '0;
          tmo_d      = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        tmo_d   = '0;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          tmo_d   = '0;
          state_d = S_RECV;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
          word_d     = {i_rx_data, word_q[DWORD-1:BYTE]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_d      = '0;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q;
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == FRAME_W) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_data    = cmd_q;
  assign o_tx_start   = (state_q == S_SEND);
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = word_q;
  assign o_busy       = (state_q == S_SEND) || (state_q == S_WAIT_TX) || (state_q == S_RECV);
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = word_cnt_q;

endmodule

// File: tb/tb_du_dump_collector.sv
// Randomized scoreboard bench for du_dump_collector: a byte-level frame model
// predicts capture-RAM writes; a monitor pops and compares them as they appear.
module tb_du_dump_collector;
  localparam int TMO   = 100;
  localparam int FRAME = 65;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_tx_done, i_rx_done;
  logic [7:0]  i_cmd, i_rx_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_wr_en, o_busy, o_done, o_error;
  logic [6:0]  o_wr_addr, o_word_count;
  logic [31:0] o_wr_data;

  du_dump_collector #(.TIMEOUT(20'd100)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_cmd(i_cmd),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          when_c;
  } wr_t;

  typedef enum {M_IDLE, M_WAIT_TX, M_RECV, M_END} mph_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  mph_t        m_phase  = M_IDLE;
  int          m_nbytes = 0;
  int          m_words  = 0;
  logic [31:0] m_acc    = '0;
  logic [7:0]  m_cmd    = '0;
  bit          m_tx_expect = 1'b0;
  int          last_tick = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Frame model: bytes are grouped four at a time, least-significant first.
  task automatic model_byte(input logic [7:0] b, input int when_c);
    last_tick = when_c;
    if (m_phase != M_RECV) return;
    m_acc = m_acc | (32'(b) << (8 * (m_nbytes % 4)));
    m_nbytes++;
    if (m_nbytes % 4 == 0) begin
      exp_q.push_back('{m_words, m_acc, when_c});
      m_words++;
      m_acc = '0;
      if (m_words == FRAME) m_phase = M_END;
    end
  endtask

  task automatic clear_pulses();
    i_start   = 1'b0;
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_pulses();
    end
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    clear_pulses();
    i_rx_data = b;
    i_rx_done = 1'b1;
    model_byte(b, cyc + 1);
  endtask

  task automatic poke_start(input logic [7:0] c);
    @(negedge clk);
    clear_pulses();
    i_start = 1'b1;
    i_cmd   = c;
  endtask

  task automatic start_txn(input logic [7:0] c);
    int n;
    @(negedge clk);
    clear_pulses();
    i_start     = 1'b1;
    i_cmd       = c;
    m_cmd       = c;
    m_tx_expect = 1'b1;
    m_phase     = M_WAIT_TX;
    m_nbytes    = 0;
    m_words     = 0;
    m_acc       = '0;
    n = 0;
    do begin
      @(negedge clk);
      clear_pulses();
      i_cmd = ~c;
      n++;
    end while (!o_tx_start && n < 10);
    if (!o_tx_start) fail("tx_start_wait", "no transmit request within 10 cycles");
    chk("start_busy", 64'(o_busy), 64'(1));
    chk("start_done_clr", 64'(o_done), 64'(0));
    chk("start_err_clr", 64'(o_error), 64'(0));
  endtask

  task automatic tx_done_pulse();
    @(negedge clk);
    clear_pulses();
    i_tx_done = 1'b1;
    m_phase   = M_RECV;
  endtask

  task automatic do_reset(input bit with_start);
    @(negedge clk);
    clear_pulses();
    i_reset = 1'b1;
    if (with_start) begin
      i_start = 1'b1;
      i_cmd   = 8'h55;
    end
    m_phase     = M_IDLE;
    m_tx_expect = 1'b0;
    exp_q.delete();
    @(negedge clk);
    clear_pulses();
    i_reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},    64'(o_busy), 64'(0));
    chk({tag, "_done"},    64'(o_done), 64'(0));
    chk({tag, "_error"},   64'(o_error), 64'(0));
    chk({tag, "_wr_en"},   64'(o_wr_en), 64'(0));
    chk({tag, "_txstart"}, 64'(o_tx_start), 64'(0));
    chk({tag, "_wcount"},  64'(o_word_count), 64'(0));
    chk({tag, "_wr_addr"}, 64'(o_wr_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(o_wr_data), 64'(0));
    chk({tag, "_tx_data"}, 64'(o_tx_data), 64'(0));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      clear_pulses();
      n++;
    end while (!o_done && n < 20);
    chk({tag, "_done"},   64'(o_done), 64'(1));
    chk({tag, "_error"},  64'(o_error), 64'(0));
    chk({tag, "_busy"},   64'(o_busy), 64'(0));
    chk({tag, "_wcount"}, 64'(o_word_count), 64'(FRAME));
    idle(1);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every transmit request and every RAM write must be predicted.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        if (m_tx_expect) begin
          chk("tx_data", 64'(o_tx_data), 64'(m_cmd));
          m_tx_expect = 1'b0;
        end else fail("tx_start", "unexpected transmit request");
      end
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          $display("FAIL wr_en: unexpected write addr=%0d data=0x%h", o_wr_addr, o_wr_data);
          n_checks++;
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr",  64'(o_wr_addr), 64'(e.addr));
          chk("wr_data",  64'(o_wr_data), 64'(e.data));
          chk("wr_cycle", 64'(cyc), 64'(e.when_c));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          n;
    i_reset = 1'b1;
    i_cmd = '0;
    i_rx_data = '0;
    clear_pulses();
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check_zero("rst");

    // start coinciding with reset must not begin a transaction
    do_reset(1'b1);
    idle(2);
    chk("rst_start_busy", 64'(o_busy), 64'(0));

    // T1: command 0x06, first word 0x12345678, rest random
    start_txn(8'h06);
    tx_done_pulse();
    rx(8'h78); rx(8'h56); rx(8'h34); rx(8'h12);
    for (int i = 4; i < FRAME * 4; i++) begin
      idle(int'($urandom_range(0, 5)));
      rx(8'($urandom));
    end
    wait_done("t1");

    // T2: word k = A5000000+k, stray start mid-frame, stray bytes afterwards
    idle(3);
    start_txn(8'($urandom));
    tx_done_pulse();
    for (int k = 0; k < FRAME; k++) begin
      w = 32'hA500_0000 + 32'(k);
      for (int b = 0; b < 4; b++) begin
        idle(int'($urandom_range(0, 3)));
        rx(w[8*b +: 8]);
        if (k == 10 && b == 1) poke_start(8'hEE);
      end
    end
    wait_done("t2");
    for (int i = 0; i < 4; i++) rx(8'($urandom));
    idle(5);
    chk("stray_wcount", 64'(o_word_count), 64'(FRAME));
    chk("stray_done",   64'(o_done), 64'(1));
    chk("stray_busy",   64'(o_busy), 64'(0));

    // T3: stop after 130 bytes, timeout expected TMO cycles after last tick
    start_txn(8'($urandom));
    tx_done_pulse();
    for (int i = 0; i < 130; i++) begin
      idle(int'($urandom_range(0, 4)));
      rx(8'($urandom));
    end
    n = 0;
    do begin
      @(negedge clk);
      clear_pulses();
      n++;
    end while (!o_error && n < 300);
    chk("tmo_cycle",  64'(cyc), 64'(last_tick + TMO));
    chk("tmo_error",  64'(o_error), 64'(1));
    chk("tmo_wcount", 64'(o_word_count), 64'(32));
    chk("tmo_done",   64'(o_done), 64'(0));
    chk("tmo_busy",   64'(o_busy), 64'(0));
    m_phase = M_IDLE;
    idle(3);
    chk("tmo_held", 64'(o_error), 64'(1));

    // T4: reset after two bytes of word 5, then restart with boundary gaps
    start_txn(8'($urandom));
    tx_done_pulse();
    for (int i = 0; i < 22; i++) begin
      idle(int'($urandom_range(0, 3)));
      rx(8'($urandom));
    end
    do_reset(1'b0);
    check_zero("midrst");
    start_txn(8'($urandom));
    tx_done_pulse();
    for (int i = 0; i < FRAME * 4; i++) begin
      if (i % 16 == 0) idle(TMO - 1);
      else idle(int'($urandom_range(0, 3)));
      rx(8'($urandom));
    end
    wait_done("t4");

    // T5: transmitter never completes
    idle(2);
    start_txn(8'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      clear_pulses();
      n++;
    end while (!o_error && n < 300);
    chk("txwait_error",  64'(o_error), 64'(1));
    chk("txwait_busy",   64'(o_busy), 64'(0));
    chk("txwait_wcount", 64'(o_word_count), 64'(0));
    m_phase = M_IDLE;
    idle(3);
    chk("final_pending", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
